// File: rtl/multicycle_main_control_if.sv
// Bundle between the multi-cycle main control FSM and the datapath / ALU control.
//   master : the control FSM (drives datapath controls, reads opcode and mem_ready)
//   slave  : the datapath side (drives opcode and mem_ready, reads controls)
// CNT_W sets the width of the retired-instruction counter and must match the
// CNT_W of the control module bound to this interface.
interface multicycle_main_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic [1:0]       ALUop;
  logic             addi;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
           RegDst, ALUSrcA, ALUSrcB, PCSource, ALUop, addi, instr_done, illegal_op,
           instr_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
           RegDst, ALUSrcA, ALUSrcB, PCSource, ALUop, addi, instr_done, illegal_op,
           instr_count, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback, stalls on mem_ready, counts retired
// instructions and flags illegal opcodes (sticky until reset).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : master side of multicycle_main_control_if (opcode/mem_ready in,
//           datapath controls, ALUop/addi, instr_done, illegal_op,
//           instr_count and debug state out)
module multicycle_main_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_main_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRtypeWb  = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done;

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    illegal_d       = illegal_q;
    count_d         = count_q;
    done            = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.ALUop       = 2'b00;
    bus.addi        = 1'b0;

    case (state_q)
      StFetch: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        bus.ALUSrcB = 2'b11;
        // Path is chosen from the live opcode here; later states use the latched copy.
        opcode_d    = bus.opcode;
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (opcode_q == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        done         = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        done         = bus.mem_ready;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExecute: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUop   = 2'b10;
        state_d     = StRtypeWb;
      end
      StRtypeWb: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        done         = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUop       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        done            = 1'b1;
        state_d         = StFetch;
      end
      StJump: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        done         = 1'b1;
        state_d      = StFetch;
      end
      StAddiExec: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUop   = 2'b10;
        bus.addi    = 1'b1;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        bus.RegWrite = 1'b1;
        done         = 1'b1;
        state_d      = StFetch;
      end
      default: state_d = StFetch;  // unreachable encodings recover to fetch
    endcase

    if (done) count_d = count_q + 1'b1;

    // Suppress every side-effecting strobe while reset is held.
    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.MemRead     = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      done            = 1'b0;
    end
    bus.instr_done = done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      opcode_q  <= 6'b000000;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized self-checking bench for multicycle_main_control. A per-opcode
// path table plus a per-state output table form the reference; a second
// instance with a 4-bit counter exercises wrap-around cheaply.
module tb_multicycle_main_control;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, memto_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic       addi, instr_done;
  } ctrl_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       mem_ready = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_count = 16'd0;
  logic        m_illegal = 1'b0;

  always #5 clk = ~clk;

  multicycle_main_control_if #(.CNT_W(16)) if_m ();
  multicycle_main_control_if #(.CNT_W(4))  if_s ();

  assign if_m.opcode    = opcode;
  assign if_m.mem_ready = mem_ready;
  assign if_s.opcode    = opcode;
  assign if_s.mem_ready = mem_ready;

  multicycle_main_control #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(if_m.master));
  multicycle_main_control #(.CNT_W(4))  dut_small (.clk(clk), .reset(reset), .bus(if_s.master));

  ctrl_t obs;
  assign obs = {if_m.PCWrite, if_m.PCWriteCond, if_m.IorD, if_m.MemRead, if_m.MemWrite,
                if_m.MemtoReg, if_m.IRWrite, if_m.RegWrite, if_m.RegDst, if_m.ALUSrcA,
                if_m.ALUSrcB, if_m.PCSource, if_m.ALUop, if_m.addi, if_m.instr_done};

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  // Output table by state number, straight from the control description.
  function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic rst);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.ior_d = 1; end
      4:  begin c.memto_reg = 1; c.reg_write = 1; c.instr_done = 1; end
      5:  begin c.mem_write = 1; c.ior_d = 1; c.instr_done = mr; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      8:  begin
        c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01;
        c.instr_done = 1;
      end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; c.addi = 1; end
      11: begin c.reg_write = 1; c.instr_done = 1; end
      default: c = '0;
    endcase
    if (rst) begin
      c.pc_write = 0; c.pc_write_cond = 0; c.mem_write = 0; c.mem_read = 0;
      c.ir_write = 0; c.reg_write = 0; c.instr_done = 0;
    end
    return c;
  endfunction

  // One clock cycle: drive inputs, check DUT against the model, advance the model.
  task automatic step(input int st, input logic mr, input logic [5:0] op, input logic rst);
    ctrl_t e;
    @(negedge clk);
    reset     = rst;
    mem_ready = mr;
    opcode    = op;
    #1;
    e = exp_ctrl(st, mr, rst);
    checks++;
    assert (if_m.state === 4'(st)) else begin
      errors++; $error("FAIL state: observed %0d expected %0d", if_m.state, st);
    end
    checks++;
    assert (obs === e) else begin
      errors++; $error("FAIL ctrl st=%0d: observed %h expected %h", st, obs, e);
    end
    checks++;
    assert (if_m.instr_count === m_count) else begin
      errors++; $error("FAIL count: observed %0d expected %0d", if_m.instr_count, m_count);
    end
    checks++;
    assert (if_s.instr_count === m_count[3:0]) else begin
      errors++; $error("FAIL count4: observed %0d expected %0d", if_s.instr_count, m_count[3:0]);
    end
    checks++;
    assert (if_m.illegal_op === m_illegal) else begin
      errors++; $error("FAIL illegal: observed %0b expected %0b", if_m.illegal_op, m_illegal);
    end
    if (rst) begin
      m_count   = 16'd0;
      m_illegal = 1'b0;
    end else begin
      if (e.instr_done) m_count = m_count + 16'd1;
      if (st == 1 && !is_legal(op)) m_illegal = 1'b1;
    end
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
    int path[$];
    for (int i = 0; i < fstall; i++) step(0, 1'b0, rnd_op(), 1'b0);
    step(0, 1'b1, rnd_op(), 1'b0);
    step(1, 1'($urandom_range(0, 1)), op, 1'b0);
    case (op)
      OP_LW:   path = '{2, 3, 4};
      OP_SW:   path = '{2, 5};
      OP_R:    path = '{6, 7};
      OP_BEQ:  path = '{8};
      OP_J:    path = '{9};
      OP_ADDI: path = '{10, 11};
      default: path = '{};
    endcase
    foreach (path[k]) begin
      if (path[k] == 3 || path[k] == 5) begin
        for (int i = 0; i < mstall; i++) step(path[k], 1'b0, rnd_op(), 1'b0);
        step(path[k], 1'b1, rnd_op(), 1'b0);
      end else begin
        // Outputs here must not depend on mem_ready or a changing opcode.
        step(path[k], 1'($urandom_range(0, 1)), rnd_op(), 1'b0);
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] ops[6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    step(0, 1'b1, 6'd0, 1'b1);  // strobes forced low while reset is held

    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 2);
    run_instr(OP_ADDI, 1, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 2, 0);
    run_instr(OP_SW, 0, 1);
    run_instr(6'b111111, 0, 0);
    run_instr(OP_R, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rnd_op(); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset in the middle of a stalled store.
    step(0, 1'b1, rnd_op(), 1'b0);
    step(1, 1'b1, OP_SW, 1'b0);
    step(2, 1'b1, rnd_op(), 1'b0);
    step(5, 1'b0, rnd_op(), 1'b0);
    step(5, 1'b0, rnd_op(), 1'b1);

    for (int n = 0; n < 20; n++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 1), $urandom_range(0, 2));
    end
    step(0, 1'b0, rnd_op(), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
